// File: rtl/serial_subtractor.sv
// Purpose : multi-cycle ripple-borrow subtractor, {borrowOut, diff} = a - b, BITS_PER_CYCLE bits per cycle.
// Latency : accept edge T -> out_valid high after edge T+N, N = DATA_WIDTH/BITS_PER_CYCLE; one op in flight.
// Backpr. : result held in DONE until out_ready; in_ready stays low from accept until the result handshake.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     operand handshake for a (minuend) and b (subtrahend)
//   out_valid/out_ready   result handshake for diff and borrowOut (and ovf)
//   diff                  (a - b) mod 2^DATA_WIDTH
//   borrowOut             1 iff a < b (unsigned)
//   ovf                   signed overflow; exists only when SERSUB_OVF_EN is defined
// Every output is driven straight from a flop; no input reaches an output combinationally.

module serial_subtractor #(
    parameter int DATA_WIDTH     = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] diff,
    output logic                  borrowOut
`ifdef SERSUB_OVF_EN
    ,
    output logic                  ovf
`endif
);

    localparam int N  = DATA_WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((DATA_WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
        $error("serial_subtractor: BITS_PER_CYCLE must divide DATA_WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;

    logic [DATA_WIDTH-1:0]     r_a_sh;
    logic [DATA_WIDTH-1:0]     r_b_sh;
    logic                      r_borrow;
    logic [CW-1:0]             r_cnt;
    logic [DATA_WIDTH-1:0]     r_diff;
    logic                      r_borrow_out;
    logic                      r_in_ready;
    logic                      r_out_valid;

    logic                      w_accept;
    logic                      w_last;
    logic [BITS_PER_CYCLE:0]   w_sub;
    logic [DATA_WIDTH-1:0]     w_diff_full;

    assign w_accept = (r_state == S_IDLE) && in_valid && r_in_ready;
    assign w_last   = (r_cnt == LAST);

    // One slice of the ripple: low bits of both shift regs minus the borrow in.
    // The extra top bit of the result is the borrow out of this slice.
    assign w_sub = {1'b0, r_a_sh[BITS_PER_CYCLE-1:0]}
                 - {1'b0, r_b_sh[BITS_PER_CYCLE-1:0]}
                 - {{BITS_PER_CYCLE{1'b0}}, r_borrow};

    // Result slices enter from the MSB side, so after N slices the oldest one
    // sits at the LSB. On the final slice w_diff_full is the complete difference.
    if (N > 1) begin : g_diff_sh
        logic [DATA_WIDTH-BITS_PER_CYCLE-1:0] r_diff_sh;

        assign w_diff_full = {w_sub[BITS_PER_CYCLE-1:0], r_diff_sh};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_diff_sh <= '0;
            end else if (r_state == S_RUN) begin
                r_diff_sh <= w_diff_full[DATA_WIDTH-1:BITS_PER_CYCLE];
            end
        end
    end else begin : g_diff_single
        assign w_diff_full = w_sub[BITS_PER_CYCLE-1:0];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_state_next = S_RUN;
            S_RUN:   if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    // Handshake flags follow the state being entered, which keeps them registered
    // and makes in_ready rise on the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_next == S_IDLE);
            r_out_valid <= (w_state_next == S_DONE);
        end
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh       <= '0;
            r_b_sh       <= '0;
            r_borrow     <= 1'b0;
            r_cnt        <= '0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    r_a_sh   <= r_a_sh >> BITS_PER_CYCLE;
                    r_b_sh   <= r_b_sh >> BITS_PER_CYCLE;
                    r_borrow <= w_sub[BITS_PER_CYCLE];
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_diff       <= w_diff_full;
                        r_borrow_out <= w_sub[BITS_PER_CYCLE];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERSUB_OVF_EN
    // Operand MSBs are consumed by the shift regs, so keep copies for overflow.
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a_msb <= a[DATA_WIDTH-1];
                r_b_msb <= b[DATA_WIDTH-1];
            end
            if ((r_state == S_RUN) && w_last) begin
                // Overflow only when signs differ and the result sign differs from a.
                r_ovf <= (r_a_msb != r_b_msb) && (w_diff_full[DATA_WIDTH-1] != r_a_msb);
            end
        end
    end

    assign ovf = r_ovf;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign borrowOut = r_borrow_out;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;

    logic       in_valid8, in_ready8, out_valid8, out_ready8, borrow8;
    logic [7:0] a8, b8, diff8;
    logic       in_valid4, in_ready4, out_valid4, out_ready4, borrow4;
    logic [7:0] a4, b4, diff4;
`ifdef SERSUB_OVF_EN
    logic       ovf8, ovf4;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.DATA_WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .diff(diff8), .borrowOut(borrow8)
`ifdef SERSUB_OVF_EN
        , .ovf(ovf8)
`endif
    );

    serial_subtractor #(.DATA_WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .diff(diff4), .borrowOut(borrow4)
`ifdef SERSUB_OVF_EN
        , .ovf(ovf4)
`endif
    );

    // Reference model: plain integer arithmetic on the operands.
    function automatic logic [7:0] ref_diff(input logic [7:0] a, input logic [7:0] b);
        int d;
        d = (int'(a) - int'(b) + 256) % 256;
        return 8'(d);
    endfunction

    function automatic logic ref_borrow(input logic [7:0] a, input logic [7:0] b);
        return (int'(a) < int'(b));
    endfunction

    function automatic logic ref_ovf(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = int'($signed(a)) - int'($signed(b));
        return (s > 127) || (s < -128);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stimulus helpers: accept an operand pair, then wait for out_valid.
    // lat = edges from the accept edge to out_valid; irdy_bad = cycles in_ready was seen high meanwhile.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, output int lat, output int irdy_bad);
        int k;
        k = 0;
        irdy_bad = 0;
        while (!in_ready8 && k < 40) begin step(); k++; end
        a8 = a; b8 = b; in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            if (in_ready8) irdy_bad++;
            step();
            lat++;
        end
    endtask

    task automatic issue4(input logic [7:0] a, input logic [7:0] b, output int lat, output int irdy_bad);
        int k;
        k = 0;
        irdy_bad = 0;
        while (!in_ready4 && k < 40) begin step(); k++; end
        a4 = a; b4 = b; in_valid4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        a4 = 8'($urandom); b4 = 8'($urandom);
        lat = 0;
        while (!out_valid4 && lat < 40) begin
            if (in_ready4) irdy_bad++;
            step();
            lat++;
        end
    endtask

    task automatic ack8();
        out_ready8 = 1'b1; step(); out_ready8 = 1'b0;
    endtask

    task automatic ack4();
        out_ready4 = 1'b1; step(); out_ready4 = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (in_ready8 !== 1'b0)  $display("FAIL reset_in_ready got=%b exp=0", in_ready8);  else n_pass++;
        n_checks++; if (out_valid8 !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid8); else n_pass++;
        n_checks++; if (diff8 !== 8'h00)     $display("FAIL reset_diff got=%h exp=00", diff8);         else n_pass++;
        n_checks++; if (borrow8 !== 1'b0)    $display("FAIL reset_borrow got=%b exp=0", borrow8);      else n_pass++;
        n_checks++; if (out_valid4 !== 1'b0) $display("FAIL reset_out_valid4 got=%b exp=0", out_valid4); else n_pass++;
`ifdef SERSUB_OVF_EN
        n_checks++; if (ovf8 !== 1'b0)       $display("FAIL reset_ovf got=%b exp=0", ovf8);            else n_pass++;
`endif
        step(); step();
        rst_n = 1'b1;
        n_checks++; if (in_ready8 !== 1'b0)  $display("FAIL reset_in_ready_pre_edge got=%b exp=0", in_ready8); else n_pass++;
        step();
        n_checks++; if (in_ready8 !== 1'b1)  $display("FAIL reset_in_ready_rise got=%b exp=1", in_ready8); else n_pass++;
        n_checks++; if (in_ready4 !== 1'b1)  $display("FAIL reset_in_ready4_rise got=%b exp=1", in_ready4); else n_pass++;
    endtask

    task automatic test_basic();
        logic [7:0] va [4] = '{8'h05, 8'h03, 8'hFF, 8'h00};
        logic [7:0] vb [4] = '{8'h03, 8'h05, 8'hFF, 8'h01};
        logic [7:0] ed;
        logic       eb;
        int lat, bad;
        for (int i = 0; i < 4; i++) begin
            ed = ref_diff(va[i], vb[i]);
            eb = ref_borrow(va[i], vb[i]);
            issue8(va[i], vb[i], lat, bad);
            n_checks++; if (diff8 !== ed)       $display("FAIL basic_diff[%0d] got=%h exp=%h", i, diff8, ed);     else n_pass++;
            n_checks++; if (borrow8 !== eb)     $display("FAIL basic_borrow[%0d] got=%b exp=%b", i, borrow8, eb); else n_pass++;
            n_checks++; if (lat != 8)           $display("FAIL basic_latency[%0d] got=%0d exp=8", i, lat);        else n_pass++;
            n_checks++; if (bad != 0 || in_ready8 !== 1'b0)
                                                $display("FAIL basic_in_ready_low[%0d] got=%0d exp=0", i, bad + int'(in_ready8)); else n_pass++;
            ack8();
            n_checks++; if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1)
                                                $display("FAIL basic_handshake[%0d] got=%b%b exp=01", i, out_valid8, in_ready8); else n_pass++;
            n_checks++; if (diff8 !== ed)       $display("FAIL basic_diff_hold[%0d] got=%h exp=%h", i, diff8, ed); else n_pass++;
        end
    endtask

    task automatic test_hold();
        int lat, bad, errs;
        errs = 0;
        issue8(8'h3C, 8'hC3, lat, bad);
        for (int i = 0; i < 5; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); in_valid8 = 1'($urandom);
            step();
            if (diff8 !== 8'h79 || borrow8 !== 1'b1 || in_ready8 !== 1'b0 || out_valid8 !== 1'b1) errs++;
        end
        n_checks++; if (errs != 0) $display("FAIL hold_stable got=%0d bad cycles exp=0 (diff=%h borrow=%b)", errs, diff8, borrow8); else n_pass++;
        in_valid8 = 1'b0;
        ack8();
        n_checks++; if (out_valid8 !== 1'b0) $display("FAIL hold_release_out_valid got=%b exp=0", out_valid8); else n_pass++;
        n_checks++; if (in_ready8 !== 1'b1)  $display("FAIL hold_release_in_ready got=%b exp=1", in_ready8);  else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat, bad, seen;
        seen = 0;
        a8 = 8'h77; b8 = 8'h11; in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        #1;
        n_checks++; if (diff8 !== 8'h00 || borrow8 !== 1'b0 || out_valid8 !== 1'b0 || in_ready8 !== 1'b0)
            $display("FAIL midreset_outputs got=%h/%b/%b/%b exp=00/0/0/0", diff8, borrow8, out_valid8, in_ready8); else n_pass++;
        for (int i = 0; i < 12; i++) begin
            if (i == 4) rst_n = 1'b1;
            step();
            if (out_valid8) seen++;
        end
        n_checks++; if (seen != 0) $display("FAIL midreset_no_out_valid got=%0d exp=0", seen); else n_pass++;
        issue8(8'h10, 8'h01, lat, bad);
        n_checks++; if (diff8 !== 8'h0F || borrow8 !== 1'b0)
            $display("FAIL midreset_after got=%h/%b exp=0f/0", diff8, borrow8); else n_pass++;
        n_checks++; if (lat != 8) $display("FAIL midreset_latency got=%0d exp=8", lat); else n_pass++;
        ack8();
    endtask

`ifdef SERSUB_OVF_EN
    task automatic test_ovf();
        logic [7:0] va [3] = '{8'h80, 8'h7F, 8'h05};
        logic [7:0] vb [3] = '{8'h01, 8'hFF, 8'h03};
        int lat, bad;
        for (int i = 0; i < 3; i++) begin
            issue8(va[i], vb[i], lat, bad);
            n_checks++; if (ovf8 !== ref_ovf(va[i], vb[i]))
                $display("FAIL ovf[%0d] got=%b exp=%b", i, ovf8, ref_ovf(va[i], vb[i])); else n_pass++;
            n_checks++; if (diff8 !== ref_diff(va[i], vb[i]) || borrow8 !== ref_borrow(va[i], vb[i]))
                $display("FAIL ovf_diff[%0d] got=%h/%b exp=%h/%b", i, diff8, borrow8, ref_diff(va[i], vb[i]), ref_borrow(va[i], vb[i])); else n_pass++;
            ack8();
        end
    endtask
`endif

    task automatic test_bpc4();
        int lat, bad;
        issue4(8'hA5, 8'h5A, lat, bad);
        n_checks++; if (diff4 !== 8'h4B)  $display("FAIL bpc4_diff got=%h exp=4b", diff4);    else n_pass++;
        n_checks++; if (borrow4 !== 1'b0) $display("FAIL bpc4_borrow got=%b exp=0", borrow4); else n_pass++;
        n_checks++; if (lat != 2)         $display("FAIL bpc4_latency got=%0d exp=2", lat);   else n_pass++;
        ack4();
        n_checks++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1)
            $display("FAIL bpc4_handshake got=%b%b exp=01", out_valid4, in_ready4); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] ra, rb;
        int lat, bad, dly;
        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            if (i == 0) begin ra = 8'h00; rb = 8'h00; end
            issue8(ra, rb, lat, bad);
            n_checks++; if (diff8 !== ref_diff(ra, rb) || borrow8 !== ref_borrow(ra, rb) || lat != 8)
                $display("FAIL b2b8[%0d] a=%h b=%h got=%h/%b lat=%0d exp=%h/%b lat=8", i, ra, rb, diff8, borrow8, lat, ref_diff(ra, rb), ref_borrow(ra, rb)); else n_pass++;
`ifdef SERSUB_OVF_EN
            n_checks++; if (ovf8 !== ref_ovf(ra, rb)) $display("FAIL b2b8_ovf[%0d] got=%b exp=%b", i, ovf8, ref_ovf(ra, rb)); else n_pass++;
`endif
            dly = $urandom_range(0, 2);
            for (int k = 0; k < dly; k++) step();
            ack8();
        end
        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            if (i == 0) begin ra = 8'h00; rb = 8'hFF; end
            issue4(ra, rb, lat, bad);
            n_checks++; if (diff4 !== ref_diff(ra, rb) || borrow4 !== ref_borrow(ra, rb) || lat != 2 || bad != 0)
                $display("FAIL b2b4[%0d] a=%h b=%h got=%h/%b lat=%0d exp=%h/%b lat=2", i, ra, rb, diff4, borrow4, lat, ref_diff(ra, rb), ref_borrow(ra, rb)); else n_pass++;
`ifdef SERSUB_OVF_EN
            n_checks++; if (ovf4 !== ref_ovf(ra, rb)) $display("FAIL b2b4_ovf[%0d] got=%b exp=%b", i, ovf4, ref_ovf(ra, rb)); else n_pass++;
`endif
            dly = $urandom_range(0, 2);
            for (int k = 0; k < dly; k++) step();
            ack4();
        end
    endtask

    initial begin
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = 8'h00; b4 = 8'h00;
        test_reset();
        test_basic();
        test_hold();
        test_reset_mid();
`ifdef SERSUB_OVF_EN
        test_ovf();
`endif
        test_bpc4();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish (%0d/%0d checks passed so far)", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
